// File: rtl/scan_pkg.sv
// scan_pkg: shared constants and FSM state type for the register-file scan engine.
package scan_pkg;
   localparam int NUM_REGS       = 32;
   localparam int IDX_W          = 5;
   localparam int DATA_W         = 32;
   localparam int CYC_W          = 17;
   localparam int DEFAULT_CYCLES = 255;
   typedef enum logic [2:0] {IDLE, RUN, SETTLE, EMIT, DONE} state_t;
endpackage

// File: rtl/scan_err_counter.sv
// scan_err_counter: saturating, synchronously clearable error counter used by the compare option.
module scan_err_counter #(
   parameter int W = 6
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/regfile_scan_engine.sv
// regfile_scan_engine: after a timed run, hijacks regfile read port A and streams {index, value} for r0..r31.
// Optional SCAN_CMP_EN adds per-register comparison against expected data and an error count.
module regfile_scan_engine
   import scan_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [CYC_W-1:0]  num_cycles,
   input  logic [IDX_W-1:0]  cpu_rs1,
   output logic [IDX_W-1:0]  rs1_in,
   input  logic [DATA_W-1:0] regA,
   output logic              test_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [DATA_W-1:0] out_data,
`ifdef SCAN_CMP_EN
   output logic [IDX_W-1:0]  exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   output logic              out_mismatch,
   output logic [IDX_W:0]    err_cnt,
`endif
   output logic              busy,
   output logic              done,
   output logic [CYC_W-1:0]  cycles_run
);
   state_t            state, state_nx;
   logic [CYC_W-1:0]  cnt;
   logic [IDX_W-1:0]  scan_idx;
   logic              accept, hs, last;

   assign accept    = start && (state == IDLE || state == DONE);
   assign hs        = state == EMIT && out_ready;
   assign last      = scan_idx == IDX_W'(NUM_REGS - 1);
   assign test_mode = state == SETTLE || state == EMIT;
   assign rs1_in    = test_mode ? scan_idx : cpu_rs1;
   assign busy      = state == RUN || test_mode;
   assign done      = state == DONE;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = start ? RUN : state;
         RUN:        state_nx = (cnt == CYC_W'(1)) ? SETTLE : RUN;
         SETTLE:     state_nx = EMIT;
         EMIT:       state_nx = out_ready ? (last ? DONE : SETTLE) : EMIT;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cycles_run <= '0;
         scan_idx   <= '0;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_data   <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt        <= (num_cycles == '0) ? CYC_W'(DEFAULT_CYCLES) : num_cycles;
            cycles_run <= '0;
         end
         if (state == RUN) begin
            cnt        <= cnt - 1'b1;
            cycles_run <= cycles_run + 1'b1;
            scan_idx   <= '0;
         end
         // regA has had the whole SETTLE cycle to reflect scan_idx
         if (state == SETTLE) begin
            out_data  <= regA;
            out_idx   <= scan_idx;
            out_valid <= 1'b1;
         end
         if (hs) begin
            out_valid <= 1'b0;
            if (!last) scan_idx <= scan_idx + 1'b1;
         end
      end
   end

`ifdef SCAN_CMP_EN
   assign exp_addr = scan_idx;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) out_mismatch <= 1'b0;
      else if (state == SETTLE) out_mismatch <= regA != exp_data;
   end

   scan_err_counter #(.W(IDX_W + 1)) u_err (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (accept),
      .inc     (hs && out_mismatch),
      .cnt     (err_cnt)
   );
`endif
endmodule
